// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared types and constants for the instruction fetch front-end
package inst_fetch_queue_pkg;
  localparam int XLEN = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(INST_BYTES);
  typedef enum logic {FETCH, FLUSH} state_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: instruction memory request/response channel
interface inst_fetch_queue_if;
  import inst_fetch_queue_pkg::*;
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  modport master(output req_valid, req_addr, input req_ready, resp_valid, resp_data);
  modport slave(input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// inst_fetch_queue_fetch_fifo: synchronous FIFO of fetched {pc,inst} entries
module inst_fetch_queue_fetch_fifo import inst_fetch_queue_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  logic    clear,
  input  entry_t  wr_data,
  output entry_t  rd_data,
  output logic [AW:0] count
);
  entry_t mem_q [DEPTH];
  entry_t mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push && !clear) mem_d[wr_ptr_q] = wr_data;
    wr_ptr_d = clear ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = clear ? '0 : rd_ptr_q + AW'(pop);
    count_d = clear ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  assign rd_data = mem_q[rd_ptr_q];
  assign count = count_q;
  // fetch credits must make overflow impossible
  push_full_a: assert property (@(posedge clk) disable iff (reset)
    !(push && !clear && count_q == (AW+1)'(DEPTH)));
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential fetcher with in-order instruction buffer and redirect flush
module inst_fetch_queue import inst_fetch_queue_pkg::*; #(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  inst_fetch_queue_if.master imem,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst
);
  state_e state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d, drop_cnt_q, drop_cnt_d, count;
  logic hs, push, pop;
  entry_t head, wr_entry;
  assign wr_entry = {resp_pc_q, imem.resp_data};
  inst_fetch_queue_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .clear(redirect),
    .wr_data(wr_entry), .rd_data(head), .count(count)
  );
  // buffered plus outstanding fetches never exceed the queue size
  assign imem.req_valid = !reset && !redirect && state_q == FETCH &&
                          ({1'b0, count} + {1'b0, inflight_q} < (CW+1)'(DEPTH));
  assign imem.req_addr = fetch_pc_q;
  assign hs = imem.req_valid && imem.req_ready;
  assign inst_valid = count != '0;
  assign pop = inst_valid && !stall && !redirect;
  assign push = imem.resp_valid && !redirect && drop_cnt_q == '0;
  assign inst_pc = inst_valid ? head.pc : '0;
  assign inst = inst_valid ? head.inst : '0;
  always_comb begin
    fetch_pc_d = redirect ? redirect_pc : hs ? fetch_pc_q + PC_INC : fetch_pc_q;
    resp_pc_d = redirect ? redirect_pc : push ? resp_pc_q + PC_INC : resp_pc_q;
    inflight_d = inflight_q + CW'(hs) - CW'(imem.resp_valid);
    drop_cnt_d = redirect ? inflight_q - CW'(imem.resp_valid)
                          : drop_cnt_q - CW'(imem.resp_valid && drop_cnt_q != '0);
    state_d = drop_cnt_d != '0 ? FLUSH : FETCH;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed bench with a latency-configurable memory model
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;
  logic clk, reset, redirect, stall;
  logic [31:0] redirect_pc, inst_pc, inst;
  logic inst_valid;
  inst_fetch_queue_if bus();
  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .imem(bus), .inst_valid(inst_valid), .inst_pc(inst_pc), .inst(inst)
  );
  int checks = 0, errors = 0, lat = 1, cyc = 0;
  logic [31:0] pat = 0, exp_addr = 0, exp_pc = 0;
  typedef struct {logic [31:0] a; int due;} req_t;
  req_t pend[$];
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_inst(input string tag, input logic [31:0] pc, input logic [31:0] data);
    int n = 0;
    while (!inst_valid && n < 20) begin
      cycle();
      #1;
      n++;
    end
    check({tag, "_valid"}, 32'(inst_valid), 1);
    check({tag, "_pc"}, inst_pc, pc);
    check({tag, "_inst"}, inst, data);
  endtask
  // memory: in-order, fixed latency, data = addr ^ pat
  always @(posedge clk) begin
    if (reset) begin
      pend.delete();
      bus.resp_valid <= 0;
      bus.resp_data <= 0;
    end else begin
      if (bus.resp_valid) void'(pend.pop_front());
      if (bus.req_valid && bus.req_ready) pend.push_back('{bus.req_addr, cyc + lat});
      if (pend.size() > 0) begin
        bus.resp_valid <= pend[0].due <= cyc + 1;
        bus.resp_data <= pend[0].a ^ pat;
      end else begin
        bus.resp_valid <= 0;
        bus.resp_data <= 0;
      end
    end
    cyc <= cyc + 1;
  end
  // request addresses and popped instructions must follow strict +4 streams
  always @(negedge clk) if (!reset) begin
    if (bus.req_valid) begin
      check("req_addr", bus.req_addr, exp_addr);
      if (bus.req_ready) exp_addr += 4;
    end
    if (inst_valid && !stall && !redirect) begin
      check("pop_pc", inst_pc, exp_pc);
      check("pop_inst", inst, exp_pc ^ pat);
      exp_pc += 4;
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    reset = 1; redirect = 0; redirect_pc = 0; stall = 0; bus.req_ready = 1;
    cycle(); cycle();
    #1;
    check("rst_req_valid", 32'(bus.req_valid), 0);
    check("rst_inst_valid", 32'(inst_valid), 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_inst", inst, 0);
    check("rst_state", 32'(dut.state_q), 32'(FETCH));
    cycle(); reset = 0;
    #1;
    check("c0_req_valid", 32'(bus.req_valid), 1);
    check("c0_req_addr", bus.req_addr, 0);
    check("c0_inst_valid", 32'(inst_valid), 0);
    cycle(); #1;
    check("c1_inst_valid", 32'(inst_valid), 0);
    cycle(); #1;
    check("c2_inst_valid", 32'(inst_valid), 1);
    check("c2_inst_pc", inst_pc, 0);
    check("c2_inst", inst, 0);
    cycle(); #1; check("c3_inst_pc", inst_pc, 4);
    cycle(); #1; check("c4_inst_pc", inst_pc, 8);
    cycle(); #1; check("c5_inst_pc", inst_pc, 12);
    cycle(); stall = 1;
    repeat (10) cycle();
    #1;
    check("stall_req_valid", 32'(bus.req_valid), 0);
    check("stall_count", 32'(dut.count), 4);
    check("stall_inflight", 32'(dut.inflight_q), 0);
    check("stall_inst_valid", 32'(inst_valid), 1);
    check("stall_head_pc", inst_pc, 32'h10);
    stall = 0;
    repeat (8) cycle();
    cycle();
    redirect = 1; redirect_pc = 32'h200; exp_addr = 32'h200; exp_pc = 32'h200;
    #1;
    check("rd_resp_valid", 32'(bus.resp_valid), 1);
    check("rd_inst_valid", 32'(inst_valid), 1);
    check("rd_req_valid", 32'(bus.req_valid), 0);
    cycle(); redirect = 0;
    #1;
    check("rd1_inst_valid", 32'(inst_valid), 0);
    check("rd1_req_valid", 32'(bus.req_valid), 1);
    check("rd1_req_addr", bus.req_addr, 32'h200);
    cycle(); #1;
    check("rd2_inst_valid", 32'(inst_valid), 0);
    cycle(); #1;
    check("rd3_inst_valid", 32'(inst_valid), 1);
    check("rd3_inst_pc", inst_pc, 32'h200);
    lat = 2;
    for (int i = 0; i < 40; i++) begin
      cycle();
      bus.req_ready = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3) == 0;
    end
    cycle(); bus.req_ready = 1; stall = 0;
    repeat (10) cycle();
    reset = 1; pat = 32'h5a5a_0000; lat = 4; exp_addr = 0; exp_pc = 0;
    cycle(); cycle(); reset = 0;
    cycle(); cycle(); cycle();
    redirect = 1; redirect_pc = 32'h100; exp_addr = 32'h100; exp_pc = 32'h100;
    #1;
    check("fl_req_valid", 32'(bus.req_valid), 0);
    check("fl_inflight", 32'(dut.inflight_q), 3);
    check("fl_resp_valid", 32'(bus.resp_valid), 0);
    cycle(); redirect = 0;
    #1;
    check("fl1_state", 32'(dut.state_q), 32'(FLUSH));
    check("fl1_drop", 32'(dut.drop_cnt_q), 3);
    check("fl1_req_valid", 32'(bus.req_valid), 0);
    cycle(); #1;
    check("fl2_state", 32'(dut.state_q), 32'(FLUSH));
    check("fl2_drop", 32'(dut.drop_cnt_q), 2);
    cycle(); #1;
    check("fl3_state", 32'(dut.state_q), 32'(FLUSH));
    check("fl3_drop", 32'(dut.drop_cnt_q), 1);
    check("fl3_req_valid", 32'(bus.req_valid), 0);
    cycle(); #1;
    check("fl4_state", 32'(dut.state_q), 32'(FETCH));
    check("fl4_req_valid", 32'(bus.req_valid), 1);
    check("fl4_req_addr", bus.req_addr, 32'h100);
    wait_inst("fl_first", 32'h100, 32'h5a5a_0100);
    reset = 1; lat = 4; exp_addr = 0; exp_pc = 0;
    cycle(); cycle(); reset = 0;
    cycle(); cycle(); cycle();
    redirect = 1; redirect_pc = 32'h300; exp_addr = 32'h300; exp_pc = 32'h300;
    cycle(); redirect = 0;
    cycle(); #1;
    check("mr_state", 32'(dut.state_q), 32'(FLUSH));
    check("mr_inflight", 32'(dut.inflight_q), 2);
    reset = 1; exp_addr = 0; exp_pc = 0;
    cycle(); #1;
    check("mr_req_valid", 32'(bus.req_valid), 0);
    check("mr_inst_valid", 32'(inst_valid), 0);
    check("mr_inst_pc", inst_pc, 0);
    check("mr_inst", inst, 0);
    check("mr_state_rst", 32'(dut.state_q), 32'(FETCH));
    check("mr_inflight_rst", 32'(dut.inflight_q), 0);
    check("mr_drop_rst", 32'(dut.drop_cnt_q), 0);
    cycle(); reset = 0; lat = 1;
    #1;
    check("mr_rel_req_valid", 32'(bus.req_valid), 1);
    check("mr_rel_req_addr", bus.req_addr, 0);
    wait_inst("mr_first", 32'h0, 32'h5a5a_0000);
    repeat (4) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
